// File: rtl/alu_pipe_mod.sv
// Two-stage (EX, WB) execute unit with register file, RF bypass, memory-hazard
// interlock and a bit-serial shift-add multiplier.
module alu_pipe_mod #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned RF_DEPTH   = 16,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            op,
    input  logic [1:0]            src1_sel,
    input  logic [1:0]            src2_sel,
    input  logic [ADDR_WIDTH-1:0] src1,
    input  logic [ADDR_WIDTH-1:0] src2,
    input  logic [1:0]            dst_sel,
    input  logic [ADDR_WIDTH-1:0] dst,
    output logic [ADDR_WIDTH-1:0] mem_a_addr,
    output logic [ADDR_WIDTH-1:0] mem_b_addr,
    input  logic [WIDTH-1:0]      word_a_rdata,
    input  logic [WIDTH-1:0]      word_b_rdata,
    input  logic                  bit_a_rdata,
    input  logic                  bit_b_rdata,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [WIDTH-1:0]      wr_data,
    output logic                  word_we,
    output logic                  bit_we,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_result,
    output logic                  flag_c,
    output logic                  flag_z,
    output logic                  flag_b
);
    localparam int unsigned RF_IW = $clog2(RF_DEPTH);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned WP1   = WIDTH + 1;
    localparam int unsigned W2    = 2 * WIDTH;

    localparam logic [3:0] OP_NOP = 4'd0,  OP_LD  = 4'd1,  OP_ADD = 4'd2,  OP_ADC = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4,  OP_SBB = 4'd5,  OP_AND = 4'd6,  OP_OR  = 4'd7;
    localparam logic [3:0] OP_XOR = 4'd8,  OP_NOT = 4'd9,  OP_SHL = 4'd10, OP_SHR = 4'd11;
    localparam logic [3:0] OP_CMP = 4'd12, OP_MUL = 4'd13;
    localparam logic [1:0] SRC_IMM = 2'd0, SRC_RF = 2'd1, SRC_WORD = 2'd2;
    localparam logic [1:0] DST_RF = 2'd0, DST_BIT = 2'd1, DST_WORD = 2'd2, DST_NONE = 2'd3;

    typedef enum logic [1:0] {EX_IDLE, EX_EXEC, EX_MUL} ex_state_t;

    ex_state_t             ex_state;
    logic [CNT_W-1:0]      mul_cnt;
    logic [3:0]            ex_op;
    logic [1:0]            ex_s1_sel, ex_s2_sel, ex_dst_sel;
    logic [ADDR_WIDTH-1:0] ex_src1, ex_src2, ex_dst;
    logic                  ex_we;
    logic [WIDTH-1:0]      rf [RF_DEPTH];
    logic                  wb_rf_we;
    logic [RF_IW-1:0]      wb_rf_idx;
    logic [W2-1:0]         mul_acc, mul_mcand;
    logic [WIDTH-1:0]      mul_mplier;

    logic                  mul_last, mul_busy, ex_done, accept;
    logic                  haz_a, haz_b, ex_wr_word, ex_wr_bit;
    logic [RF_IW-1:0]      idx_a, idx_b;
    logic [WIDTH-1:0]      rf_a, rf_b, op_a, op_b, res;
    logic [WP1-1:0]        add_full, sub_full;
    logic                  mul_first;
    logic [W2-1:0]         mul_base, mul_mc, mul_sum;
    logic [WIDTH-1:0]      mul_mp;
    logic                  nc, nz, nb, upd;

    function automatic logic [WIDTH-1:0] pick(input logic [1:0] sel, input logic [ADDR_WIDTH-1:0] src,
                                              input logic [WIDTH-1:0] rfv, input logic [WIDTH-1:0] wordv,
                                              input logic bitv);
        case (sel)
            SRC_IMM:  pick = WIDTH'(src);
            SRC_RF:   pick = rfv;
            SRC_WORD: pick = wordv;
            default:  pick = WIDTH'(bitv);
        endcase
    endfunction

    function automatic logic writes(input logic [3:0] o, input logic [1:0] ds);
        writes = (ds != DST_NONE) && (o != OP_NOP) && (o != OP_CMP) && (o <= OP_MUL);
    endfunction

    assign mem_a_addr = src1;
    assign mem_b_addr = src2;

    assign mul_last = (mul_cnt == CNT_W'(WIDTH - 1));
    assign mul_busy = (ex_state == EX_MUL) && !mul_last;
    assign ex_done  = (ex_state == EX_EXEC) || ((ex_state == EX_MUL) && mul_last);

    // A memory source may not be fetched while a pending write to it sits in EX or WB.
    assign ex_wr_word = (ex_state != EX_IDLE) && ex_we && (ex_dst_sel == DST_WORD);
    assign ex_wr_bit  = (ex_state != EX_IDLE) && ex_we && (ex_dst_sel == DST_BIT);
    assign haz_a = (src1_sel == SRC_WORD) ? ((ex_wr_word && ex_dst == src1) || (word_we && wr_addr == src1))
                 : (src1_sel == 2'd3)     ? ((ex_wr_bit  && ex_dst == src1) || (bit_we  && wr_addr == src1))
                 : 1'b0;
    assign haz_b = (src2_sel == SRC_WORD) ? ((ex_wr_word && ex_dst == src2) || (word_we && wr_addr == src2))
                 : (src2_sel == 2'd3)     ? ((ex_wr_bit  && ex_dst == src2) || (bit_we  && wr_addr == src2))
                 : 1'b0;
    assign in_ready = rst && !mul_busy && !(in_valid && (haz_a || haz_b));
    assign accept   = in_valid && in_ready;

    // Operand fetch with WB-stage bypass into the register file read.
    assign idx_a = ex_src1[RF_IW-1:0];
    assign idx_b = ex_src2[RF_IW-1:0];
    assign rf_a  = (wb_rf_we && wb_rf_idx == idx_a) ? out_result : rf[idx_a];
    assign rf_b  = (wb_rf_we && wb_rf_idx == idx_b) ? out_result : rf[idx_b];
    assign op_a  = pick(ex_s1_sel, ex_src1, rf_a, word_a_rdata, bit_a_rdata);
    assign op_b  = pick(ex_s2_sel, ex_src2, rf_b, word_b_rdata, bit_b_rdata);

    assign add_full = {1'b0, op_a} + {1'b0, op_b} + WP1'((ex_op == OP_ADC) && flag_c);
    assign sub_full = {1'b0, op_a} - {1'b0, op_b} - WP1'((ex_op == OP_SBB) && flag_b);

    // First multiply step uses the live operands; later steps use the latched copies.
    assign mul_first = (mul_cnt == '0);
    assign mul_base  = mul_first ? '0 : mul_acc;
    assign mul_mc    = mul_first ? W2'(op_a) : mul_mcand;
    assign mul_mp    = mul_first ? op_b : mul_mplier;
    assign mul_sum   = mul_base + (mul_mp[0] ? mul_mc : '0);

    always_comb begin
        res = '0;
        nc  = flag_c;
        nz  = flag_z;
        nb  = flag_b;
        upd = 1'b1;
        case (ex_op)
            OP_LD:                  begin res = op_a; upd = 1'b0; end
            OP_ADD, OP_ADC:         begin res = add_full[WIDTH-1:0]; nc = add_full[WIDTH]; end
            OP_SUB, OP_SBB, OP_CMP: begin res = sub_full[WIDTH-1:0]; nb = sub_full[WIDTH]; end
            OP_AND:                 res = op_a & op_b;
            OP_OR:                  res = op_a | op_b;
            OP_XOR:                 res = op_a ^ op_b;
            OP_NOT:                 res = ~op_a;
            OP_SHL:                 begin res = op_a << 1; nc = op_a[WIDTH-1]; end
            OP_SHR:                 begin res = op_a >> 1; nc = op_a[0]; end
            OP_MUL:                 begin res = mul_sum[WIDTH-1:0]; nc = |mul_sum[W2-1:WIDTH]; end
            default:                upd = 1'b0;
        endcase
        if (upd) nz = (res == '0);
    end

    // EX stage: instruction capture and state sequencing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_state   <= EX_IDLE;
            mul_cnt    <= '0;
            ex_op      <= OP_NOP;
            ex_s1_sel  <= SRC_IMM;
            ex_s2_sel  <= SRC_IMM;
            ex_dst_sel <= DST_NONE;
            ex_src1    <= '0;
            ex_src2    <= '0;
            ex_dst     <= '0;
            ex_we      <= 1'b0;
        end else if (mul_busy) begin
            mul_cnt <= mul_cnt + CNT_W'(1);
        end else if (accept) begin
            ex_state   <= (op == OP_MUL) ? EX_MUL : EX_EXEC;
            mul_cnt    <= '0;
            ex_op      <= op;
            ex_s1_sel  <= src1_sel;
            ex_s2_sel  <= src2_sel;
            ex_dst_sel <= dst_sel;
            ex_src1    <= src1;
            ex_src2    <= src2;
            ex_dst     <= dst;
            ex_we      <= writes(op, dst_sel);
        end else begin
            ex_state <= EX_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
        end else if (ex_state == EX_MUL) begin
            mul_acc    <= mul_sum;
            mul_mcand  <= mul_mc << 1;
            mul_mplier <= mul_mp >> 1;
        end
    end

    // WB stage: retire, write strobes and flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            word_we    <= 1'b0;
            bit_we     <= 1'b0;
            wb_rf_we   <= 1'b0;
            wb_rf_idx  <= '0;
            flag_c     <= 1'b0;
            flag_z     <= 1'b0;
            flag_b     <= 1'b0;
        end else begin
            out_valid <= ex_done;
            word_we   <= ex_done && ex_we && (ex_dst_sel == DST_WORD);
            bit_we    <= ex_done && ex_we && (ex_dst_sel == DST_BIT);
            wb_rf_we  <= ex_done && ex_we && (ex_dst_sel == DST_RF);
            if (ex_done) begin
                out_result <= res;
                wr_addr    <= ex_dst;
                wr_data    <= res;
                wb_rf_idx  <= ex_dst[RF_IW-1:0];
                flag_c     <= nc;
                flag_z     <= nz;
                flag_b     <= nb;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
        end else if (wb_rf_we) begin
            rf[wb_rf_idx] <= out_result;
        end
    end
endmodule

// File: tb/tb_alu_pipe_mod.sv
// Directed bench for alu_pipe_mod: a driver pushes expected retires into a
// scoreboard queue, a negedge monitor pops and compares on every out_valid.
module tb_alu_pipe_mod;
    localparam logic [3:0] NOP = 4'd0, LD = 4'd1, ADD = 4'd2, ADC = 4'd3, SUB = 4'd4, SBB = 4'd5;
    localparam logic [3:0] AND_ = 4'd6, OR_ = 4'd7, XOR_ = 4'd8, NOT_ = 4'd9, SHL = 4'd10;
    localparam logic [3:0] SHR = 4'd11, CMP = 4'd12, MUL = 4'd13;
    localparam logic [1:0] S_IMM = 2'd0, S_RF = 2'd1, S_WM = 2'd2, S_BM = 2'd3;
    localparam logic [1:0] D_RF = 2'd0, D_BM = 2'd1, D_WM = 2'd2, D_NONE = 2'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready;
    logic [3:0] op;
    logic [1:0] src1_sel, src2_sel, dst_sel;
    logic [7:0] src1, src2, dst, mem_a_addr, mem_b_addr, wr_addr, wr_data, out_result;
    logic [7:0] word_a_rdata, word_b_rdata;
    logic       bit_a_rdata, bit_b_rdata, word_we, bit_we, out_valid, flag_c, flag_z, flag_b;

    typedef struct {
        int         id;
        logic [7:0] res;
        bit         chk_res;
        logic [2:0] czb;
        logic [1:0] strobes;
        int         lat;
        int         acc;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         passed = 0;
    int         cyc = 0;
    int         vid = 0;
    int         st;
    logic [7:0] wmem [256];
    logic       bmem [256];

    alu_pipe_mod #(.WIDTH(8), .RF_DEPTH(16), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .src1_sel(src1_sel), .src2_sel(src2_sel), .src1(src1), .src2(src2),
        .dst_sel(dst_sel), .dst(dst), .mem_a_addr(mem_a_addr), .mem_b_addr(mem_b_addr),
        .word_a_rdata(word_a_rdata), .word_b_rdata(word_b_rdata),
        .bit_a_rdata(bit_a_rdata), .bit_b_rdata(bit_b_rdata),
        .wr_addr(wr_addr), .wr_data(wr_data), .word_we(word_we), .bit_we(bit_we),
        .out_valid(out_valid), .out_result(out_result),
        .flag_c(flag_c), .flag_z(flag_z), .flag_b(flag_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Word and bit memories with one-cycle read latency.
    always @(posedge clk) begin
        word_a_rdata <= wmem[mem_a_addr];
        word_b_rdata <= wmem[mem_b_addr];
        bit_a_rdata  <= bmem[mem_a_addr];
        bit_b_rdata  <= bmem[mem_b_addr];
        if (word_we) wmem[wr_addr] <= wr_data;
        if (bit_we)  bmem[wr_addr] <= wr_data[0];
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_retire: got out_valid=1 result 0x%0h, expected no retire", out_result);
            end else begin
                automatic exp_t e = sb.pop_front();
                if (e.chk_res) chk($sformatf("v%0d_result", e.id), int'(out_result), int'(e.res));
                chk($sformatf("v%0d_flags_czb", e.id), int'({flag_c, flag_z, flag_b}), int'(e.czb));
                chk($sformatf("v%0d_strobes_wb", e.id), int'({word_we, bit_we}), int'(e.strobes));
                chk($sformatf("v%0d_latency", e.id), cyc - e.acc + 1, e.lat);
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [1:0] s1s, input logic [7:0] s1,
                         input logic [1:0] s2s, input logic [7:0] s2, input logic [1:0] ds,
                         input logic [7:0] d, input logic [7:0] er, input logic [2:0] czb,
                         input logic [1:0] strobes, input bit push, output int stalls);
        exp_t e;
        bit   ok;
        vid++;
        in_valid = 1'b1; op = o; src1_sel = s1s; src1 = s1; src2_sel = s2s; src2 = s2;
        dst_sel = ds; dst = d;
        stalls = 0;
        ok = 1'b0;
        while (!ok && stalls < 40) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else stalls++;
        end
        if (!ok) begin
            total++;
            $display("FAIL v%0d_accept: got in_ready stuck low, expected acceptance", vid);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) begin
            e.id = vid; e.res = er; e.chk_res = (o != NOP); e.czb = czb; e.strobes = strobes;
            e.lat = (o == MUL) ? 9 : 2; e.acc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin wmem[i] = 8'h00; bmem[i] = 1'b0; end
        rst = 1'b0; in_valid = 1'b0; op = NOP; src1_sel = S_IMM; src2_sel = S_IMM;
        src1 = '0; src2 = '0; dst_sel = D_NONE; dst = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_result", int'(out_result), 0);
        chk("rst_flags", int'({flag_c, flag_z, flag_b}), 0);
        chk("rst_strobes", int'({word_we, bit_we}), 0);
        chk("rst_wr", int'({wr_addr, wr_data}), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;

        //     op    s1sel  s1     s2sel  s2     dsel    dst    res    czb     {w,b}
        issue(ADD,  S_IMM, 8'h7F, S_IMM, 8'h81, D_RF,   8'h02, 8'h00, 3'b110, 2'b00, 1, st);
        idle(3);
        issue(LD,   S_IMM, 8'hFF, S_IMM, 8'h00, D_RF,   8'h01, 8'hFF, 3'b110, 2'b00, 1, st);
        issue(ADD,  S_RF,  8'h01, S_IMM, 8'h01, D_RF,   8'h03, 8'h00, 3'b110, 2'b00, 1, st);
        chk("stall_rf_raw", st, 0);
        issue(ADC,  S_RF,  8'h03, S_IMM, 8'h00, D_RF,   8'h04, 8'h01, 3'b000, 2'b00, 1, st);
        chk("stall_adc", st, 0);
        issue(LD,   S_IMM, 8'h55, S_IMM, 8'h00, D_WM,   8'h10, 8'h55, 3'b000, 2'b10, 1, st);
        issue(LD,   S_WM,  8'h10, S_IMM, 8'h00, D_RF,   8'h05, 8'h55, 3'b000, 2'b00, 1, st);
        chk("stall_word_raw", st, 2);
        issue(MUL,  S_IMM, 8'h0F, S_IMM, 8'h11, D_RF,   8'h06, 8'hFF, 3'b000, 2'b00, 1, st);
        issue(MUL,  S_IMM, 8'h10, S_IMM, 8'h10, D_RF,   8'h07, 8'h00, 3'b110, 2'b00, 1, st);
        chk("stall_mul", st, 7);
        issue(CMP,  S_IMM, 8'h03, S_IMM, 8'h05, D_RF,   8'h08, 8'hFE, 3'b101, 2'b00, 1, st);
        issue(LD,   S_RF,  8'h08, S_IMM, 8'h00, D_NONE, 8'h00, 8'h00, 3'b101, 2'b00, 1, st);
        issue(SBB,  S_IMM, 8'h05, S_IMM, 8'h03, D_NONE, 8'h00, 8'h01, 3'b100, 2'b00, 1, st);
        issue(SUB,  S_IMM, 8'h00, S_IMM, 8'h01, D_NONE, 8'h00, 8'hFF, 3'b101, 2'b00, 1, st);
        issue(AND_, S_IMM, 8'hF0, S_IMM, 8'h3C, D_NONE, 8'h00, 8'h30, 3'b101, 2'b00, 1, st);
        issue(XOR_, S_IMM, 8'hAA, S_IMM, 8'hAA, D_NONE, 8'h00, 8'h00, 3'b111, 2'b00, 1, st);
        issue(OR_,  S_IMM, 8'hA0, S_IMM, 8'h05, D_NONE, 8'h00, 8'hA5, 3'b101, 2'b00, 1, st);
        issue(NOT_, S_IMM, 8'hFF, S_IMM, 8'h00, D_NONE, 8'h00, 8'h00, 3'b111, 2'b00, 1, st);
        issue(SHL,  S_IMM, 8'h81, S_IMM, 8'h00, D_NONE, 8'h00, 8'h02, 3'b101, 2'b00, 1, st);
        issue(SHR,  S_IMM, 8'h02, S_IMM, 8'h00, D_NONE, 8'h00, 8'h01, 3'b001, 2'b00, 1, st);
        issue(LD,   S_IMM, 8'h01, S_IMM, 8'h00, D_BM,   8'h20, 8'h01, 3'b001, 2'b01, 1, st);
        issue(AND_, S_BM,  8'h20, S_IMM, 8'hFF, D_RF,   8'h09, 8'h01, 3'b001, 2'b00, 1, st);
        chk("stall_bit_raw", st, 2);
        issue(ADD,  S_RF,  8'h09, S_RF,  8'h04, D_NONE, 8'h00, 8'h02, 3'b001, 2'b00, 1, st);
        issue(NOP,  S_IMM, 8'h00, S_IMM, 8'h00, D_RF,   8'h01, 8'h00, 3'b001, 2'b00, 1, st);
        issue(LD,   S_RF,  8'h01, S_IMM, 8'h00, D_NONE, 8'h33, 8'hFF, 3'b001, 2'b00, 1, st);
        idle(4);
        chk("drain_before_reset", sb.size(), 0);

        // Abort a multiply in its fourth iteration; it must never retire.
        issue(MUL,  S_IMM, 8'h03, S_IMM, 8'h05, D_RF,   8'h01, 8'h0F, 3'b000, 2'b00, 0, st);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midmul_in_ready", int'(in_ready), 0);
        chk("midmul_out_valid", int'(out_valid), 0);
        chk("midmul_out_result", int'(out_result), 0);
        chk("midmul_flags", int'({flag_c, flag_z, flag_b}), 0);
        chk("midmul_strobes", int'({word_we, bit_we}), 0);
        chk("midmul_wr_addr", int'(wr_addr), 0);
        chk("midmul_wr_data", int'(wr_data), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(12);
        chk("post_abort_in_ready", int'(in_ready), 1);
        issue(LD,   S_RF,  8'h01, S_IMM, 8'h00, D_NONE, 8'h00, 8'h00, 3'b000, 2'b00, 1, st);
        issue(LD,   S_RF,  8'h04, S_IMM, 8'h00, D_NONE, 8'h00, 8'h00, 3'b000, 2'b00, 1, st);
        idle(5);
        chk("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_pipe_mod.md
# alu_pipe_mod

Pipelined, parametrised execute unit; successor to the single-cycle ALU/flag/register-file cluster. It accepts one instruction per cycle over a valid/ready handshake and fetches operands from immediates, an internal register file, or external word/bit memories. It executes in a 2-stage pipeline (EX, WB) with register-file bypass, memory-hazard interlock and a multi-cycle shift-add multiplier. It sits between instruction decode and the data memories.

## Interface
- WIDTH, 8, datapath width
- RF_DEPTH, 16, register-file entries (power of two)
- ADDR_WIDTH, 8, memory/operand address width (≥ WIDTH not required; src/dst are ADDR_WIDTH)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction present
- in_ready  out  1  instruction accepted when in_valid & in_ready
- op  in  4  opcode
- src1_sel, src2_sel  in  2  00 immediate, 01 RF, 10 word mem, 11 bit mem
- src1, src2  in  ADDR_WIDTH  immediate value (low WIDTH bits) or address
- dst_sel  in  2  00 RF, 01 bit mem, 10 word mem, 11 none
- dst  in  ADDR_WIDTH  destination address
- mem_a_addr, mem_b_addr  out  ADDR_WIDTH  = src1, src2 (combinational)
- word_a_rdata, word_b_rdata  in  WIDTH  word memory data, 1-cycle latency
- bit_a_rdata, bit_b_rdata  in  1  bit memory data, 1-cycle latency
- wr_addr  out  ADDR_WIDTH  write address
- wr_data  out  WIDTH  write data (bit mem uses bit 0)
- word_we, bit_we  out  1  memory write strobes
- out_valid  out  1  retire pulse, one per instruction
- out_result  out  WIDTH  retired result
- flag_c, flag_z, flag_b  out  1  carry, zero, borrow

## Operation
- Opcodes (a = src1 operand, b = src2 operand): 0 NOP; 1 LD a; 2 ADD a+b; 3 ADC a+b+C; 4 SUB a−b; 5 SBB a−b−B; 6 AND; 7 OR; 8 XOR; 9 NOT ~a; 10 SHL a<<1; 11 SHR a>>1 (logical); 12 CMP a−b (flags only, no write); 13 MUL low WIDTH bits of a*b; 14–15 reserved, treated as NOP.
- Operand formation: immediate = src[WIDTH-1:0]; RF index = src[$clog2(RF_DEPTH)-1:0]; bit-mem operand zero-extended.
- Flags update at end of EX for ops 2–13 only; NOP/reserved leave flags unchanged.
  - Z = (result == 0). For CMP, result means the difference.
  - ADD/ADC: C = carry out. SUB/SBB/CMP: B = borrow out.
  - SHL: C = a[WIDTH-1]. SHR: C = a[0]. MUL: C = (high half ≠ 0).
  - Untouched flags hold their value.
- Arithmetic is modulo 2^WIDTH, unsigned.
- Writes occur only in WB, and only if dst_sel ≠ 11 and op ∉ {0, 12, 14, 15}. RF write goes to index dst[$clog2(RF_DEPTH)-1:0]; bit/word memory write strobe is asserted for one cycle.
- RF bypass: an EX operand whose RF index matches a WB-stage RF write takes the WB result.
- Memory interlock: in_ready = 0 when in_valid and a word/bit-memory source address equals the memory destination of the same kind held in EX or WB.
- MUL is shift-add, one bit per cycle, WIDTH cycles in EX. Operands are latched in the first EX cycle. in_ready = 0 until the final iteration cycle.
- States of EX: IDLE, EXEC (single-cycle op), MUL(k), k = 0..WIDTH-1.
  - MUL(WIDTH-1) → WB.
  - EXEC → WB.
  - EX empty → IDLE.
- Reset (any time, including mid-MUL): pipeline emptied, MUL aborted, RF and flags cleared to 0, no write strobes.

## Timing
- Reset values: in_ready 0 while rst low, 1 after release; out_valid, word_we, bit_we, flags, out_result, wr_addr, wr_data all 0.
- Single-cycle op accepted at cycle T:
  - memory addresses driven at T;
  - EX at T+1;
  - flags visible at T+2;
  - out_valid, write strobe and result at T+2.
- Latency 2, throughput 1/cycle.
- MUL accepted at T: out_valid at T+1+WIDTH. Next instruction can be accepted at T+WIDTH.
- Back-to-back RF RAW needs no stall (bypass). Memory RAW stalls 1–2 cycles until the producer leaves WB.
- ADC/SBB directly after a flag-setting op see the updated flags (no stall).
- If in_valid is low, EX empties and out_valid drops the following cycle.

## Test plan
- Reset then ADD imm 0x7F + imm 0x81 → RF[2]: out_valid at T+2, out_result 0x00, Z=1, C=1, RF[2]=0x00.
- ADD RF[1]=0xFF + imm 1 → RF[3]; then ADC RF[3] + imm 0 back-to-back → second result 0x01 (bypassed 0x00 + C=1).
- Word write of 0x55 to addr 0x10, then LD from word mem 0x10 next cycle → in_ready low until the write retires; result 0x55.
- MUL 0x0F × 0x11 (WIDTH=8) → result 0xFF after 1+8 cycles, C=0. MUL 0x10 × 0x10 → result 0x00, C=1, Z=1. in_ready low throughout.
- CMP 0x03 vs 0x05 → B=1, Z=0, no write strobe, out_valid high.
- rst asserted during MUL(3) → all outputs 0 immediately, no retire after release, RF reads 0.
